// File: rtl/icnd2110_pkg.sv
// Shared definitions for the ICND2110 output channel: bus widths, frame
// framing lengths and the channel FSM state encoding.
package icnd2110_pkg;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_HEADER_BITS = 32;
    localparam int DEF_LATCH_BITS  = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_LATCH  = 2'd3
    } state_e;

endpackage

// File: rtl/icnd2110_bit_shifter.sv
// MSB-first word shifter with a programmable bit-cell divider.
// A bit cell lasts 2^(divisor+1) clk cycles: clock low for the first half,
// high for the second. Loading in the cycle word_done is high gives a
// gap-free stream; when nothing is loaded the shifter idles with clock low.
module icnd2110_bit_shifter
    import icnd2110_pkg::*;
#(
    parameter int DW = DEF_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] word,
    input  logic [1:0]    divisor,
    output logic          data,
    output logic          clock,
    output logic          busy,
    output logic          word_done
);

    localparam int BW = $clog2(DW);

    logic [DW-1:0] shift_q, shift_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [3:0]    cyc_q, cyc_d;
    logic          busy_q, busy_d;
    logic [4:0]    period;
    logic [3:0]    half_cyc;
    logic [3:0]    last_cyc;
    logic          cell_end;

    // Bit-cell timing derived from the divisor
    always_comb begin
        period   = 5'd2 << divisor;
        half_cyc = 4'd1 << divisor;
        last_cyc = 4'(period - 5'd1);
        cell_end = busy_q && (cyc_q == last_cyc);
    end

    assign data      = busy_q & shift_q[DW-1];
    assign clock     = busy_q && (cyc_q >= half_cyc);
    assign busy      = busy_q;
    assign word_done = cell_end && (bit_q == BW'(DW - 1));

    // Next-state: load a word, advance the cell counter, shift at cell end
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        shift_d = shift_q;
        bit_d   = bit_q;
        cyc_d   = cyc_q;
        busy_d  = busy_q;
        if (load) begin
            shift_d = word;
            bit_d   = '0;
            cyc_d   = '0;
            busy_d  = 1'b1;
        end else if (cell_end) begin
            cyc_d = '0;
            if (word_done) begin
                busy_d = 1'b0;
            end else begin
                bit_d   = bit_q + BW'(1);
                shift_d = {shift_q[DW-2:0], 1'b0};
            end
        end else if (busy_q) begin
            cyc_d = cyc_q + 4'd1;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
        if (rst) begin
            shift_q <= '0;
            bit_q   <= '0;
            cyc_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/icnd2110_out.sv
// One ICND2110 strip channel: frame FSM (header, data, latch), page and
// address arithmetic, double-pixel word sequencing and the single-outstanding
// SRAM read handshake. Serialisation is done by icnd2110_bit_shifter.
module icnd2110_out
    import icnd2110_pkg::*;
#(
    parameter int ADDRESS_BUS_WIDTH = DEF_ADDR_W,
    parameter int DATA_BUS_WIDTH    = DEF_DATA_W,
    parameter int HEADER_BITS       = DEF_HEADER_BITS,
    parameter int LATCH_BITS        = DEF_LATCH_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDRESS_BUS_WIDTH-1:0] word_count,
    input  logic [ADDRESS_BUS_WIDTH-1:0] start_address,
    input  logic [1:0]                   clock_divisor,
    input  logic [7:0]                   page_count,
    input  logic                         double_pixel,
    input  logic                         start_toggle,
    output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
    output logic                         read_request,
    input  logic [DATA_BUS_WIDTH-1:0]    read_data,
    input  logic                         read_finished_strobe,
    output logic                         data_out,
    output logic                         clock_out
);

    localparam int AW        = ADDRESS_BUS_WIDTH;
    localparam int DW        = DATA_BUS_WIDTH;
    // Header and latch are sent as whole zero words through the shifter
    localparam int HDR_WORDS = HEADER_BITS / DW;
    localparam int LAT_WORDS = LATCH_BITS / DW;

    state_e        state_q, state_d;
    logic          toggle_q, toggle_d;
    logic          pending_q, pending_d;
    logic [7:0]    page_index_q, page_index_d;
    logic [7:0]    page_cnt_q, page_cnt_d;
    logic [AW-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]    div_q, div_d;
    logic          dp_q, dp_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW+1:0] pix_base_q, pix_base_d;   // first word of the pixel being fetched
    logic [1:0]    pix_off_q, pix_off_d;     // word within that pixel
    logic          pix_rep_q, pix_rep_d;     // second pass of a doubled pixel
    logic [AW:0]   data_left_q, data_left_d; // words still to be shifted this frame
    logic [7:0]    seg_cnt_q, seg_cnt_d;     // header/latch word counter
    logic [DW-1:0] buf_q, buf_d;
    logic          buf_valid_q, buf_valid_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;

    logic          sh_load;
    logic [DW-1:0] sh_word;
    logic          sh_data, sh_clock, sh_busy, sh_done;
    logic          data_slot;
    logic          toggle_seen;
    logic          fetch_done;
    logic [AW+1:0] pix_remain;
    logic [1:0]    pix_len;

    icnd2110_bit_shifter #(.DW(DW)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .word      (sh_word),
        .divisor   (div_q),
        .data      (sh_data),
        .clock     (sh_clock),
        .busy      (sh_busy),
        .word_done (sh_done)
    );

    assign toggle_seen  = (start_toggle != toggle_q);
    assign read_request = req_q;
    assign read_address = addr_q;
    assign data_out     = sh_data;
    // The latch period shifts zeros with the serial clock held low
    assign clock_out    = sh_clock && (state_q != ST_LATCH);

    // Fetch sequencer status: finished, and length of the current pixel (max 3 words)
    always_comb begin
        fetch_done = (pix_base_q >= {2'b00, word_cnt_q});
        pix_remain = {2'b00, word_cnt_q} - pix_base_q;
        pix_len    = (pix_remain > (AW+2)'(3)) ? 2'd3 : pix_remain[1:0];
    end

    // Frame FSM, word scheduling and read handshake
    always_comb begin
        state_d      = state_q;
        toggle_d     = toggle_q;
        pending_d    = pending_q;
        page_index_d = page_index_q;
        page_cnt_d   = page_cnt_q;
        word_cnt_d   = word_cnt_q;
        div_d        = div_q;
        dp_d         = dp_q;
        base_d       = base_q;
        pix_base_d   = pix_base_q;
        pix_off_d    = pix_off_q;
        pix_rep_d    = pix_rep_q;
        data_left_d  = data_left_q;
        seg_cnt_d    = seg_cnt_q;
        buf_d        = buf_q;
        buf_valid_d  = buf_valid_q;
        req_d        = req_q;
        addr_d       = addr_q;
        sh_load      = 1'b0;
        sh_word      = '0;
        data_slot    = 1'b0;

        // Requests arriving mid-frame collapse into one pending frame
        if (state_q != ST_IDLE && toggle_seen) begin
            pending_d = 1'b1;
            toggle_d  = start_toggle;
        end

        case (state_q)
            ST_IDLE: begin
                if (pending_q || toggle_seen) begin
                    state_d     = ST_HEADER;
                    pending_d   = 1'b0;
                    toggle_d    = start_toggle;
                    word_cnt_d  = word_count;
                    div_d       = clock_divisor;
                    dp_d        = double_pixel;
                    page_cnt_d  = (page_count == 8'd0) ? 8'd1 : page_count;
                    base_d      = start_address + {{(AW-8){1'b0}}, page_index_q} * word_count;
                    pix_base_d  = '0;
                    pix_off_d   = '0;
                    pix_rep_d   = 1'b0;
                    data_left_d = double_pixel ? {word_count, 1'b0} : {1'b0, word_count};
                    seg_cnt_d   = '0;
                    buf_valid_d = 1'b0;
                    sh_load     = 1'b1;
                end
            end
            ST_HEADER: begin
                if (sh_done) begin
                    if (seg_cnt_q == 8'(HDR_WORDS - 1)) begin
                        data_slot = 1'b1;
                    end else begin
                        seg_cnt_d = seg_cnt_q + 8'd1;
                        sh_load   = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                // A slot opens at the end of a word or while stalled waiting for data
                data_slot = sh_done || !sh_busy;
            end
            ST_LATCH: begin
                if (sh_done) begin
                    if (seg_cnt_q == 8'(LAT_WORDS - 1)) begin
                        state_d      = ST_IDLE;
                        page_index_d = (page_index_q >= page_cnt_q - 8'd1) ? 8'd0
                                                                           : page_index_q + 8'd1;
                    end else begin
                        seg_cnt_d = seg_cnt_q + 8'd1;
                        sh_load   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Feed the shifter: next data word, stall, or start the latch
        if (data_slot) begin
            state_d = ST_DATA;
            if (data_left_q == '0) begin
                state_d   = ST_LATCH;
                seg_cnt_d = '0;
                sh_load   = 1'b1;
            end else if (buf_valid_q) begin
                sh_load     = 1'b1;
                sh_word     = buf_q;
                buf_valid_d = 1'b0;
                data_left_d = data_left_q - (AW+1)'(1);
            end
        end

        // Read handshake: one request at a time, prefetching into a single buffer
        if (req_q && read_finished_strobe) begin
            buf_d       = read_data;
            buf_valid_d = 1'b1;
            req_d       = 1'b0;
        end else if (!req_q && !buf_valid_q && !fetch_done &&
                     (state_q == ST_HEADER || state_q == ST_DATA)) begin
            req_d  = 1'b1;
            addr_d = base_q + pix_base_q[AW-1:0] + {{(AW-2){1'b0}}, pix_off_q};
            if ({1'b0, pix_off_q} + 3'd1 < {1'b0, pix_len}) begin
                pix_off_d = pix_off_q + 2'd1;
            end else begin
                pix_off_d = '0;
                if (dp_q && !pix_rep_q) begin
                    pix_rep_d = 1'b1;
                end else begin
                    pix_rep_d  = 1'b0;
                    pix_base_d = pix_base_q + (AW+2)'(3);
                end
            end
        end
    end

    // State registers; reset aborts any frame and drops the request at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            toggle_q     <= start_toggle;
            pending_q    <= 1'b0;
            page_index_q <= '0;
            page_cnt_q   <= 8'd1;
            word_cnt_q   <= '0;
            div_q        <= '0;
            dp_q         <= 1'b0;
            base_q       <= '0;
            pix_base_q   <= '0;
            pix_off_q    <= '0;
            pix_rep_q    <= 1'b0;
            data_left_q  <= '0;
            seg_cnt_q    <= '0;
            buf_q        <= '0;
            buf_valid_q  <= 1'b0;
            req_q        <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            toggle_q     <= toggle_d;
            pending_q    <= pending_d;
            page_index_q <= page_index_d;
            page_cnt_q   <= page_cnt_d;
            word_cnt_q   <= word_cnt_d;
            div_q        <= div_d;
            dp_q         <= dp_d;
            base_q       <= base_d;
            pix_base_q   <= pix_base_d;
            pix_off_q    <= pix_off_d;
            pix_rep_q    <= pix_rep_d;
            data_left_q  <= data_left_d;
            seg_cnt_q    <= seg_cnt_d;
            buf_q        <= buf_d;
            buf_valid_q  <= buf_valid_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
        end
    end

endmodule

// File: tb/tb_icnd2110_out.sv
// Scoreboard bench for icnd2110_out: expected serial bits are queued when a
// frame is requested and popped on every rising clock_out; an SRAM model
// answers reads with a programmable latency.
module tb_icnd2110_out;
    import icnd2110_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] word_count;
    logic [15:0] start_address;
    logic [1:0]  clock_divisor;
    logic [7:0]  page_count;
    logic        double_pixel;
    logic        start_toggle;
    logic [15:0] read_address;
    logic        read_request;
    logic [15:0] read_data;
    logic        read_finished_strobe;
    logic        data_out;
    logic        clock_out;

    icnd2110_out dut (
        .clk                  (clk),
        .rst                  (rst),
        .word_count           (word_count),
        .start_address        (start_address),
        .clock_divisor        (clock_divisor),
        .page_count           (page_count),
        .double_pixel         (double_pixel),
        .start_toggle         (start_toggle),
        .read_address         (read_address),
        .read_request         (read_request),
        .read_data            (read_data),
        .read_finished_strobe (read_finished_strobe),
        .data_out             (data_out),
        .clock_out            (clock_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_pass;
    logic [15:0] mem [0:1023];
    bit          exp_q [$];
    logic [15:0] rd_log [$];
    int          rd_lat;
    int          half_exp;
    bit          mon_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected stream: header zeros, then words in (optionally doubled) pixel order
    task automatic push_frame(input logic [15:0] base, input int wc, input bit dp);
        int          seq [$];
        int          n;
        logic [15:0] a;
        logic [15:0] w;
        for (int i = 0; i < DEF_HEADER_BITS; i++) exp_q.push_back(1'b0);
        for (int p = 0; p < wc; p += 3) begin
            n = (wc - p < 3) ? wc - p : 3;
            for (int r = 0; r < (dp ? 2 : 1); r++)
                for (int j = 0; j < n; j++) seq.push_back(p + j);
        end
        foreach (seq[s]) begin
            a = base + 16'(seq[s]);
            w = mem[a[9:0]];
            for (int b = 15; b >= 0; b--) exp_q.push_back(w[b]);
        end
    endtask

    task automatic toggle_start();
        @(posedge clk); #1;
        start_toggle = ~start_toggle;
    endtask

    // Wait for the expected bits to drain, then for the latch period to pass
    task automatic wait_frame_done(input string tag, input int div);
        int n;
        int bt;
        n  = 0;
        bt = 2 << div;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        repeat ((DEF_LATCH_BITS + 2) * bt + 8) @(posedge clk);
        #1;
        check({tag, "_idle_clock"}, clock_out, 1'b0);
        check({tag, "_idle_req"}, read_request, 1'b0);
    endtask

    // SRAM model: answer each request after rd_lat cycles with a one-cycle strobe
    initial begin
        logic [15:0] a;
        read_finished_strobe = 1'b0;
        read_data            = '0;
        forever begin
            @(posedge clk); #1;
            if (read_request && !rst) begin
                a = read_address;
                for (int i = 0; i < rd_lat; i++) begin
                    @(posedge clk); #1;
                end
                if (read_request && !rst && read_address == a) begin
                    rd_log.push_back(a);
                    read_data            = mem[a[9:0]];
                    read_finished_strobe = 1'b1;
                    @(posedge clk); #1;
                    read_finished_strobe = 1'b0;
                    read_data            = '0;
                    check("req_dropped_after_strobe", read_request, 1'b0);
                end
            end
        end
    end

    // Serial monitor: score bits on rising clock_out, check cell shape
    initial begin
        logic prev_clk;
        logic prev_data;
        int   hi_run;
        int   lo_run;
        bit   data_moved;
        bit   b;
        prev_clk   = 1'b0;
        prev_data  = 1'b0;
        hi_run     = 0;
        lo_run     = 1000;
        data_moved = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_clk  = clock_out;
                prev_data = data_out;
                hi_run    = 0;
                lo_run    = 1000;
                continue;
            end
            if (clock_out && !prev_clk) begin
                check("low_phase_len", lo_run >= half_exp, 1'b1);
                check("bit_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    check("bit", data_out, b);
                end
                hi_run     = 1;
                data_moved = 1'b0;
            end else if (clock_out) begin
                hi_run++;
                if (data_out != prev_data) data_moved = 1'b1;
            end else if (prev_clk) begin
                check("high_phase_len", hi_run, half_exp);
                check("data_stable_high", data_moved, 1'b0);
                lo_run = 1;
            end else begin
                lo_run++;
            end
            prev_clk  = clock_out;
            prev_data = data_out;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bases [4];
        n_checks = 0;
        n_pass   = 0;
        rd_lat   = 0;
        half_exp = 1;
        mon_en   = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'((i * 40503) ^ 16'h3C5A);
        mem[10'h100] = 16'hA5A5;
        mem[10'h101] = 16'h0001;
        mem[10'h102] = 16'h8000;
        rst           = 1'b1;
        word_count    = '0;
        start_address = '0;
        clock_divisor = '0;
        page_count    = '0;
        double_pixel  = 1'b0;
        start_toggle  = 1'b0;

        // Reset state
        #1;
        check("rst_data_out", data_out, 1'b0);
        check("rst_clock_out", clock_out, 1'b0);
        check("rst_read_request", read_request, 1'b0);
        check("rst_read_address", read_address, 16'h0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        mon_en = 1'b1;

        // 1: basic frame, divisor 0
        start_address = 16'h0100; word_count = 16'd3; clock_divisor = 2'd0; page_count = 8'd1;
        half_exp = 1;
        rd_log.delete();
        push_frame(16'h0100, 3, 1'b0);
        toggle_start();
        wait_frame_done("t1", 0);
        check("t1_reads", rd_log.size(), 3);
        if (rd_log.size() == 3)
            for (int i = 0; i < 3; i++) check("t1_read_addr", rd_log[i], 16'h0100 + 16'(i));

        // 3: double pixel, whole pixels and a trailing partial pixel
        double_pixel = 1'b1;
        rd_log.delete();
        push_frame(16'h0100, 3, 1'b1);
        toggle_start();
        wait_frame_done("t3", 0);
        check("t3_read_count_3_or_6", (rd_log.size() == 3 || rd_log.size() == 6), 1'b1);
        word_count = 16'd4;
        push_frame(16'h0100, 4, 1'b1);
        toggle_start();
        wait_frame_done("t3b", 0);
        double_pixel = 1'b0;
        word_count   = 16'd3;

        // 4: slow reads, divisor 3 (prefetch hides latency), then divisor 0 (stalls)
        rd_lat = 40; clock_divisor = 2'd3; half_exp = 8;
        push_frame(16'h0100, 3, 1'b0);
        toggle_start();
        wait_frame_done("t4", 3);
        clock_divisor = 2'd0; half_exp = 1;
        push_frame(16'h0100, 3, 1'b0);
        toggle_start();
        wait_frame_done("t4_stall", 0);
        rd_lat = 0;

        // 5: three toggles while busy produce exactly one extra frame
        rd_log.delete();
        push_frame(16'h0100, 3, 1'b0);
        push_frame(16'h0100, 3, 1'b0);
        toggle_start();
        repeat (20) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            toggle_start();
            repeat (5) @(posedge clk);
        end
        wait_frame_done("t5", 0);
        repeat (300) @(posedge clk);
        check("t5_no_extra_frame", exp_q.size(), 0);
        check("t5_reads", rd_log.size(), 6);

        // 2: page stepping with wrap
        page_count = 8'd3; word_count = 16'd4;
        bases = '{16'h0100, 16'h0104, 16'h0108, 16'h0100};
        for (int f = 0; f < 4; f++) begin
            rd_log.delete();
            push_frame(bases[f], 4, 1'b0);
            toggle_start();
            wait_frame_done("t2", 0);
            check("t2_reads", rd_log.size(), 4);
            if (rd_log.size() != 0) check("t2_base_addr", rd_log[0], bases[f]);
        end

        // 6: reset mid-DATA (page 1 frame), then restart from page 0
        push_frame(16'h0104, 4, 1'b0);
        toggle_start();
        repeat (80) @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("t6_rst_data_out", data_out, 1'b0);
        check("t6_rst_clock_out", clock_out, 1'b0);
        check("t6_rst_read_request", read_request, 1'b0);
        check("t6_rst_read_address", read_address, 16'h0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);
        mon_en = 1'b1;
        rd_log.delete();
        push_frame(16'h0100, 4, 1'b0);
        toggle_start();
        wait_frame_done("t6", 0);
        check("t6_reads", rd_log.size(), 4);
        if (rd_log.size() != 0) check("t6_restart_page0", rd_log[0], 16'h0100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
